// File: rtl/clock_pkg.sv
// Shared constants and state encodings for the hourly chime logic.
// Hours are packed BCD {tens,ones}; chime counts are small binary values.
package clock_pkg;

    localparam int MAX_HOUR = 12;
    localparam int BCD_W    = 4;
    localparam int HOUR_W   = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CHIME = 1'b1
    } state_e;

    typedef enum logic {
        BEEP = 1'b0,
        GAP  = 1'b1
    } phase_e;

endpackage

// File: rtl/bcd_hour_to_bin.sv
// Combinational packed-BCD hour to binary converter with range check.
// o_valid is low for non-decimal digits or hours outside 1..MAX_HOUR.
module bcd_hour_to_bin
#(
    parameter int MAX_HOUR = clock_pkg::MAX_HOUR
)
(
    input  logic [2*clock_pkg::BCD_W-1:0] i_bcd,
    output logic [clock_pkg::HOUR_W-1:0]  o_bin,
    output logic                          o_valid
);
    import clock_pkg::*;

    logic [BCD_W-1:0] w_tens;
    logic [BCD_W-1:0] w_ones;
    logic [7:0]       w_sum;
    logic             w_digits_ok;
    logic             w_range_ok;

    assign w_tens = i_bcd[2*BCD_W-1:BCD_W];
    assign w_ones = i_bcd[BCD_W-1:0];

    // Widest case (15*10 + 15) still fits in 8 bits, so no overflow handling.
    assign w_sum       = ({4'd0, w_tens} * 8'd10) + {4'd0, w_ones};
    assign w_digits_ok = (w_tens <= 4'd9) && (w_ones <= 4'd9);
    assign w_range_ok  = (w_sum >= 8'd1) && (w_sum <= 8'(MAX_HOUR));

    assign o_valid = w_digits_ok && w_range_ok;
    assign o_bin   = w_sum[HOUR_W-1:0];

endmodule

// File: rtl/tell_the_time.sv
// Hourly chime: latches the hour on a rising tell and beeps Di once per hour,
// alternating beep/gap on each change of the Second input.
module tell_the_time
#(
    parameter int MAX_HOUR = clock_pkg::MAX_HOUR
)
(
    input  logic       CP,
    input  logic       nCR,
    input  logic [7:0] Hour12,
    input  logic [7:0] Second,
    input  logic       tell,
    output logic       Di,
    output logic [3:0] oH,
    output logic [3:0] oS
);
    import clock_pkg::*;

    state_e      r_state;
    phase_e      r_phase;
    logic        r_tell_d;
    logic [7:0]  r_sec_d;

    logic        w_tick;
    logic        w_rise;
    logic [3:0]  w_hour_bin;
    logic        w_hour_ok;
    logic [3:0]  w_os_inc;

    bcd_hour_to_bin #(
        .MAX_HOUR (MAX_HOUR)
    ) u_hour_conv (
        .i_bcd   (Hour12),
        .o_bin   (w_hour_bin),
        .o_valid (w_hour_ok)
    );

    // Any change of the seconds value is one tick, including wraps and jumps.
    assign w_tick   = (Second != r_sec_d);
    assign w_rise   = tell && !r_tell_d;
    assign w_os_inc = oS + 4'd1;

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            r_state  <= IDLE;
            r_phase  <= BEEP;
            r_tell_d <= 1'b0;
            r_sec_d  <= 8'h00;
            Di       <= 1'b0;
            oH       <= 4'd0;
            oS       <= 4'd0;
        end else begin
            r_tell_d <= tell;
            r_sec_d  <= Second;

            case (r_state)
                IDLE: begin
                    Di <= 1'b0;
                    // A tick on the load edge is deliberately dropped.
                    if (w_rise && w_hour_ok) begin
                        r_state <= CHIME;
                        r_phase <= BEEP;
                        oH      <= w_hour_bin;
                        oS      <= 4'd0;
                        Di      <= 1'b1;
                    end
                end

                CHIME: begin
                    if (!tell) begin
                        r_state <= IDLE;
                        Di      <= 1'b0;
                    end else if (w_tick) begin
                        if (r_phase == BEEP) begin
                            Di      <= 1'b0;
                            r_phase <= GAP;
                        end else begin
                            oS <= w_os_inc;
                            if (w_os_inc == oH) begin
                                r_state <= IDLE;
                                Di      <= 1'b0;
                            end else begin
                                Di      <= 1'b1;
                                r_phase <= BEEP;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    Di      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tell_the_time.sv
// Randomized scoreboard bench for tell_the_time: a tick-count model predicts
// Di/oH/oS each cycle, a negedge monitor compares against the DUT.
module tb_tell_the_time;

    logic       CP = 1'b0;
    logic       nCR;
    logic [7:0] Hour12;
    logic [7:0] Second;
    logic       tell;
    logic       Di;
    logic [3:0] oH;
    logic [3:0] oS;

    tell_the_time dut (
        .CP     (CP),
        .nCR    (nCR),
        .Hour12 (Hour12),
        .Second (Second),
        .tell   (tell),
        .Di     (Di),
        .oH     (oH),
        .oS     (oS)
    );

    always #5 CP = ~CP;

    typedef struct {
        logic       di;
        logic [3:0] oh;
        logic [3:0] os;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: a chime of N beeps spans 2N ticks; after k ticks
    // the buzzer is on when k is even and oS is floor(k/2).
    bit         m_act;
    int         m_k, m_n;
    int         m_oh, m_os;
    bit         p_tell;
    logic [7:0] p_sec;

    function automatic bit hour_ok(input logic [7:0] h, output int v);
        int t, o;
        t = int'(h[7:4]);
        o = int'(h[3:0]);
        v = 10 * t + o;
        return (t <= 9) && (o <= 9) && (v >= 1) && (v <= 12);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        int t, o;
        t = int'(s[7:4]);
        o = int'(s[3:0]);
        if (t >= 5 && o >= 9) return 8'h00;
        if (o >= 9) return {4'(t + 1), 4'h0};
        return {4'(t), 4'(o + 1)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    endtask

    task automatic step();
        exp_t e;
        int   v;
        bit   tick, rise;
        if (!nCR) begin
            m_act = 0; m_k = 0; m_oh = 0; m_os = 0;
            p_tell = 0; p_sec = 8'h00;
        end else begin
            tick = (Second != p_sec);
            rise = tell && !p_tell;
            if (!m_act) begin
                if (rise && hour_ok(Hour12, v)) begin
                    m_act = 1; m_n = v; m_k = 0; m_oh = v; m_os = 0;
                end
            end else if (!tell) begin
                m_act = 0;
            end else if (tick) begin
                m_k++;
                m_os = m_k / 2;
                if (m_k == 2 * m_n) m_act = 0;
            end
            p_tell = tell;
            p_sec  = Second;
        end
        e.di = m_act && (m_k % 2 == 0);
        e.oh = 4'(m_oh);
        e.os = 4'(m_os);
        q.push_back(e);
        @(posedge CP);
        #1;
    endtask

    always @(negedge CP) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("Di", int'(Di), int'(e.di));
            chk("oH", int'(oH), int'(e.oh));
            chk("oS", int'(oS), int'(e.os));
        end
    end

    task automatic run_chime(input logic [7:0] h, input int abort_beeps);
        int guard;
        Hour12 = h;
        tell   = 1'b1;
        Second = bcd_inc(Second);
        step();
        guard = 0;
        while (m_act && guard < 200) begin
            Hour12 = 8'($urandom);
            if (abort_beeps > 0 && m_k == 2 * abort_beeps) begin
                tell = 1'b0;
                step();
                step();
                break;
            end
            if ($urandom_range(0, 1) == 1)
                Second = ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd_inc(Second);
            step();
            guard++;
        end
        if (guard >= 200) begin
            n_total++;
            $display("FAIL chime_timeout: still chiming after %0d cycles, required done", guard);
        end
        // Held level (high unless aborted) with ticks must not restart a chime.
        repeat (6) begin
            Second = bcd_inc(Second);
            step();
        end
        tell = 1'b0;
        step();
    endtask

    task automatic run_invalid(input logic [7:0] h);
        Hour12 = h;
        tell   = 1'b1;
        Second = bcd_inc(Second);
        step();
        repeat (4) begin
            Second = bcd_inc(Second);
            step();
        end
        tell = 1'b0;
        step();
    endtask

    initial begin
        logic [7:0] h;
        int         v;
        nCR    = 1'b0;
        tell   = 1'b1;
        Hour12 = 8'h05;
        Second = 8'h55;
        repeat (6) begin
            Second = bcd_inc(Second);
            step();
        end
        tell = 1'b0;
        step();
        nCR = 1'b1;
        repeat (2) step();

        Second = 8'h50;
        run_chime(8'h11, 0);
        run_chime(8'h12, 0);
        run_chime(8'h01, 0);
        run_chime(8'h07, 3);
        run_invalid(8'h13);
        run_invalid(8'h00);
        run_invalid(8'h1A);

        repeat (4) begin
            h = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            if (hour_ok(h, v)) run_chime(h, 0);
            else run_invalid(h);
        end
        repeat (2) run_invalid(8'($urandom_range(8'h13, 8'hFF)));
        run_chime(8'h09, 2);

        // Reset asserted mid-chime clears outputs immediately.
        Hour12 = 8'h10;
        tell   = 1'b1;
        Second = bcd_inc(Second);
        step();
        repeat (3) begin
            Second = bcd_inc(Second);
            step();
        end
        @(negedge CP);
        #2;
        nCR = 1'b0;
        #1;
        chk("async_rst_Di", int'(Di), 0);
        chk("async_rst_oH", int'(oH), 0);
        chk("async_rst_oS", int'(oS), 0);
        tell = 1'b0;
        step();
        nCR = 1'b1;
        repeat (3) step();

        @(negedge CP);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
